// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl_if
//  Purpose  : Request/enable/IRET inputs and take/vector/status outputs of irq_ctrl
//  Revision : 1.0  initial release
// ============================================================================
interface irq_ctrl_if #(
    parameter int N_SRC = 8
);
    logic [N_SRC-1:0] i_irq_req;
    logic [N_SRC-1:0] i_irq_mask;
    logic             i_int_en;
    logic             i_iret;
    logic             o_irq_take;
    logic [15:0]      o_irq_vector;
    logic [N_SRC-1:0] o_pending;
    logic [N_SRC-1:0] o_in_service;
    logic [1:0]       o_depth;
    logic             o_bad_iret;

    modport master (
        output i_irq_req, i_irq_mask, i_int_en, i_iret,
        input  o_irq_take, o_irq_vector, o_pending, o_in_service, o_depth, o_bad_iret
    );

    modport slave (
        input  i_irq_req, i_irq_mask, i_int_en, i_iret,
        output o_irq_take, o_irq_vector, o_pending, o_in_service, o_depth, o_bad_iret
    );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl
//  Purpose  : Edge-latched priority interrupt controller with nested in-service stack
//  Revision : 1.0  initial release
// ============================================================================
module irq_ctrl #(
    parameter int          N_SRC      = 8,
    parameter int          MAX_NEST   = 3,
    parameter logic [15:0] VEC_BASE   = 16'h0020,
    parameter int          VEC_STRIDE = 4
) (
    input  wire logic  i_clk,
    input  wire logic  i_rst,
    irq_ctrl_if.slave  bus
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_TAKE   = 2'd1;
    localparam logic [1:0] c_SETTLE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_SRC-1:0] req_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] in_service_q;
    logic [IW-1:0]    stack_q [MAX_NEST];
    logic [1:0]       depth_q;
    logic [15:0]      vector_q;
    logic             bad_q;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_eligible;
    logic [IW-1:0]    w_winner;
    logic [IW-1:0]    w_top;
    logic             w_take;
    logic             w_pop;

    assign w_rise     = bus.i_irq_req & ~req_q;
    assign w_eligible = pending_q & bus.i_irq_mask;

    // Descending scan so the lowest eligible index is the one left standing.
    always_comb begin
        w_winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = IW'(i);
            end
        end
    end

    always_comb begin
        w_top = '0;
        if (depth_q != 2'd0) begin
            w_top = stack_q[depth_q - 2'd1];
        end
    end

    // An IRET in the same cycle blocks the take so it is re-judged against the popped stack.
    assign w_take = (state_q == c_IDLE) && (|w_eligible) && bus.i_int_en && !bus.i_iret
                  && (depth_q < 2'(MAX_NEST))
                  && ((depth_q == 2'd0) || (w_winner < w_top));
    assign w_pop  = bus.i_iret && (depth_q != 2'd0);

    always_comb begin
        state_d = c_IDLE;
        case (state_q)
            c_IDLE:   state_d = w_take ? c_TAKE : c_IDLE;
            c_TAKE:   state_d = c_SETTLE;
            c_SETTLE: state_d = c_IDLE;
            default:  state_d = c_IDLE;
        endcase
    end

    // A fresh edge on the source being taken wins over the clear.
    always_comb begin
        pending_d = pending_q;
        if (w_take) begin
            pending_d[w_winner] = 1'b0;
        end
        pending_d = pending_d | w_rise;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= c_IDLE;
            req_q        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            depth_q      <= 2'd0;
            vector_q     <= VEC_BASE;
            bad_q        <= 1'b0;
            for (int i = 0; i < MAX_NEST; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            req_q     <= bus.i_irq_req;
            pending_q <= pending_d;
            bad_q     <= bus.i_iret && (depth_q == 2'd0);
            if (w_take) begin
                stack_q[depth_q]       <= w_winner;
                depth_q                <= depth_q + 2'd1;
                in_service_q[w_winner] <= 1'b1;
                vector_q               <= VEC_BASE + 16'(w_winner) * 16'(VEC_STRIDE);
            end else if (w_pop) begin
                depth_q             <= depth_q - 2'd1;
                in_service_q[w_top] <= 1'b0;
            end
        end
    end

    assign bus.o_irq_take   = (state_q == c_TAKE);
    assign bus.o_irq_vector = vector_q;
    assign bus.o_pending    = pending_q;
    assign bus.o_in_service = in_service_q;
    assign bus.o_depth      = depth_q;
    assign bus.o_bad_iret   = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ctrl
//  Purpose  : Directed and random stimulus for irq_ctrl against a queue-based reference
//  Revision : 1.0  initial release
// ============================================================================
module tb_irq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_ctrl_if #(.N_SRC(8)) ifc ();

    irq_ctrl #(
        .N_SRC(8), .MAX_NEST(3), .VEC_BASE(16'h0020), .VEC_STRIDE(4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc.slave)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference: pending set, stack of active sources, cycles since last take.
    bit [7:0]  m_pend;
    bit [7:0]  m_req_prev;
    int        m_stack[$];
    int        m_phase;
    bit [15:0] m_vec;
    bit        m_bad;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit [7:0] req, input bit [7:0] mask,
                              input bit en, input bit iret, input bit r);
        bit [7:0] elig;
        int       win;
        bit       take;
        if (r) begin
            m_pend = '0; m_req_prev = '0; m_stack.delete();
            m_phase = 0; m_vec = 16'h0020; m_bad = 1'b0;
            return;
        end
        elig = m_pend & mask;
        win  = -1;
        for (int i = 7; i >= 0; i--) if (elig[i]) win = i;
        take = (m_phase == 0) && (win >= 0) && en && !iret && (m_stack.size() < 3)
             && ((m_stack.size() == 0) || (win < m_stack[$]));
        m_bad = iret && (m_stack.size() == 0);
        if (iret && m_stack.size() > 0) void'(m_stack.pop_back());
        if (take) begin
            m_stack.push_back(win);
            m_vec = 16'(16'h0020 + win * 4);
            m_pend[win] = 1'b0;
        end
        m_pend = m_pend | (req & ~m_req_prev);
        m_req_prev = req;
        m_phase = take ? 1 : (m_phase == 1 ? 2 : 0);
    endtask

    task automatic check_model();
        bit [7:0] isv = '0;
        foreach (m_stack[k]) isv[m_stack[k]] = 1'b1;
        chk("take",       16'(ifc.o_irq_take),   16'(m_phase == 1));
        chk("vector",     ifc.o_irq_vector,      m_vec);
        chk("pending",    16'(ifc.o_pending),    16'(m_pend));
        chk("in_service", 16'(ifc.o_in_service), 16'(isv));
        chk("depth",      16'(ifc.o_depth),      16'(m_stack.size()));
        chk("bad_iret",   16'(ifc.o_bad_iret),   16'(m_bad));
    endtask

    task automatic cyc(input bit [7:0] req, input bit [7:0] mask,
                       input bit en, input bit iret, input bit r);
        rst            = r;
        ifc.i_irq_req  = req;
        ifc.i_irq_mask = mask;
        ifc.i_int_en   = en;
        ifc.i_iret     = iret;
        @(posedge clk);
        model_step(req, mask, en, iret, r);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic iret1();
        cyc(8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
    endtask

    bit [7:0] cur_req;
    bit [7:0] rmask;

    initial begin
        rst = 1'b1;
        ifc.i_irq_req = '0; ifc.i_irq_mask = 8'hFF; ifc.i_int_en = 1'b1; ifc.i_iret = 1'b0;
        m_pend = '0; m_req_prev = '0; m_phase = 0; m_vec = 16'h0020; m_bad = 1'b0;

        // Reset values
        do_reset();
        chk("rst_take",   16'(ifc.o_irq_take), 16'h0000);
        chk("rst_vector", ifc.o_irq_vector,    16'h0020);
        chk("rst_depth",  16'(ifc.o_depth),    16'h0000);

        // Stray IRET
        for (int i = 0; i < 3; i++) begin
            iret1();
            chk("stray_bad",   16'(ifc.o_bad_iret), 16'h0001);
            chk("stray_depth", 16'(ifc.o_depth),    16'h0000);
            idle(1);
        end

        // Single take of source 3
        cyc(8'h08, 8'hFF, 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("single_take",  16'(ifc.o_irq_take), 16'h0001);
        chk("single_vec",   ifc.o_irq_vector,    16'h002C);
        chk("single_depth", 16'(ifc.o_depth),    16'h0001);
        idle(2);
        iret1();
        chk("single_ret_depth", 16'(ifc.o_depth),      16'h0000);
        chk("single_ret_isv",   16'(ifc.o_in_service), 16'h0000);

        // Nesting 5 then 2; 6 must wait until the stack drains
        cyc(8'h20, 8'hFF, 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("nest5_vec", ifc.o_irq_vector, 16'h0034);
        idle(2);
        cyc(8'h04, 8'hFF, 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("nest2_vec",   ifc.o_irq_vector, 16'h0028);
        chk("nest2_depth", 16'(ifc.o_depth), 16'h0002);
        idle(2);
        cyc(8'h40, 8'hFF, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("nest6_pend", 16'(ifc.o_pending),  16'h0040);
        chk("nest6_take", 16'(ifc.o_irq_take), 16'h0000);
        iret1();
        idle(1);
        iret1();
        chk("nest_drained", 16'(ifc.o_depth), 16'h0000);
        idle(1);
        chk("nest6_taken", 16'(ifc.o_irq_take), 16'h0001);
        chk("nest6_vec",   ifc.o_irq_vector,    16'h0038);
        idle(2);
        iret1();

        // Simultaneous 1 and 4, then masked pending
        do_reset();
        cyc(8'h12, 8'hFF, 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("sim_first_vec", ifc.o_irq_vector, 16'h0024);
        idle(2);
        iret1();
        idle(1);
        chk("sim_second_vec", ifc.o_irq_vector, 16'h0030);
        idle(2);
        iret1();
        cyc(8'h10, 8'hEF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(8'h00, 8'hEF, 1'b1, 1'b0, 1'b0);
        chk("masked_pend", 16'(ifc.o_pending),  16'h0010);
        chk("masked_take", 16'(ifc.o_irq_take), 16'h0000);
        idle(1);
        chk("unmasked_take", 16'(ifc.o_irq_take), 16'h0001);
        idle(2);
        iret1();

        // Full stack 6,4,2 then request 0
        do_reset();
        cyc(8'h40, 8'hFF, 1'b1, 1'b0, 1'b0); idle(3);
        cyc(8'h10, 8'hFF, 1'b1, 1'b0, 1'b0); idle(3);
        cyc(8'h04, 8'hFF, 1'b1, 1'b0, 1'b0); idle(3);
        chk("full_depth", 16'(ifc.o_depth), 16'h0003);
        cyc(8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("full_notake", 16'(ifc.o_irq_take), 16'h0000);
        iret1();
        chk("full_pop_take",  16'(ifc.o_irq_take), 16'h0000);
        chk("full_pop_depth", 16'(ifc.o_depth),    16'h0002);
        idle(1);
        chk("full_after_take", 16'(ifc.o_irq_take),   16'h0001);
        chk("full_after_vec",  ifc.o_irq_vector,      16'h0020);
        chk("full_after_dep",  16'(ifc.o_depth),      16'h0003);

        // Reset during TAKE
        do_reset();
        cyc(8'h02, 8'hFF, 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("rt_take", 16'(ifc.o_irq_take), 16'h0001);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
        chk("rt_take0",  16'(ifc.o_irq_take),   16'h0000);
        chk("rt_vec0",   ifc.o_irq_vector,      16'h0020);
        chk("rt_isv0",   16'(ifc.o_in_service), 16'h0000);
        chk("rt_depth0", 16'(ifc.o_depth),      16'h0000);
        cyc(8'h02, 8'hFF, 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("rt_retake",     16'(ifc.o_irq_take), 16'h0001);
        chk("rt_retake_vec", ifc.o_irq_vector,    16'h0024);

        // Randomized traffic
        do_reset();
        cur_req = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) cur_req[b] = ~cur_req[b];
            rmask = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hFF;
            cyc(cur_req, rmask, $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Priority interrupt controller in front of the `cpu` core's interrupt port. It latches rising edges on up to eight request lines and picks the highest-priority enabled pending source. It then issues a one-cycle `o_irq_take` pulse with that source's vector, and tracks nested in-service sources so a handler is pre-empted only by a strictly higher priority. It pops the in-service stack on the CPU's `o_iret_detected`, so its depth always mirrors the CPU's `_irq_depth`.

## Interface
- `N_SRC`, 8: number of request lines; bit 0 is highest priority.
- `MAX_NEST`, 3: in-service stack depth; must not exceed the CPU depth counter range.
- `VEC_BASE`, 16'h0020: vector of source 0.
- `VEC_STRIDE`, 4: byte distance between consecutive source vectors.

Ports:
- `i_clk`  in  1  single clock, rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_irq_req`  in  N_SRC  raw request lines, edge-detected internally.
- `i_irq_mask`  in  N_SRC  1 = source enabled.
- `i_int_en`  in  1  CPU global enable (`o_int_en`).
- `i_iret`  in  1  CPU `o_iret_detected`, one-cycle pulse.
- `o_irq_take`  out  1  to CPU `i_irq_take`, one-cycle pulse.
- `o_irq_vector`  out  16  to CPU `i_irq_vector`, valid while `o_irq_take` is high.
- `o_pending`  out  N_SRC  latched pending bits.
- `o_in_service`  out  N_SRC  one-hot-per-level set of active sources.
- `o_depth`  out  2  current nesting depth, 0..MAX_NEST.
- `o_bad_iret`  out  1  one-cycle pulse on an IRET with depth 0.

## Operation
- Edge detect: `req_q` holds the previous `i_irq_req`. A 0->1 transition sampled at an edge sets that pending bit at the same edge. Level-held requests do not re-trigger.
- Eligible set = `o_pending & i_irq_mask`. Winner = lowest eligible index.
- Take condition, evaluated in IDLE:
  - eligible set is non-zero;
  - `i_int_en` = 1;
  - `i_iret` = 0;
  - depth < MAX_NEST;
  - depth = 0, or winner index < index on top of stack.
- FSM:
  - IDLE: if the take condition holds, go to TAKE.
  - TAKE: go to SETTLE unconditionally.
  - SETTLE: go to IDLE unconditionally. SETTLE gives the CPU one cycle to update its depth.
- Entering TAKE, at the same edge:
  - register the winner index;
  - clear its pending bit;
  - push it onto the stack;
  - set its `o_in_service` bit;
  - increment depth.
- `o_irq_take` = (state == TAKE).
- `o_irq_vector` = VEC_BASE + index*VEC_STRIDE, computed modulo 2^16. It is registered and held until the next take.
- IRET, any state:
  - depth > 0: pop the stack, clear that source's `o_in_service` bit, decrement depth.
  - depth = 0: depth stays 0 and `o_bad_iret` pulses the following cycle.
- A masked pending bit stays pending and becomes eligible when unmasked.

## Timing
- Reset values: `o_irq_take`=0, `o_irq_vector`=VEC_BASE, `o_pending`=0, `o_in_service`=0, `o_depth`=0, `o_bad_iret`=0, state IDLE, `req_q`=0.
- Latency: a request edge sampled at edge k sets pending at edge k. The FSM enters TAKE at edge k+1, so `o_irq_take` is high during cycle k+1..k+2. Depth reads +1 from edge k+1.
- Minimum spacing between two takes is 3 cycles (TAKE, SETTLE, IDLE).
- Simultaneous new edge on source s and take clearing s: the set wins and s stays pending.
- Simultaneous IRET and take condition: the take is suppressed that cycle and is re-evaluated against the post-pop stack next cycle.
- IRET during TAKE: the push happened at the entry edge, so the IRET pops the entry just pushed. This is legal and depth returns to its prior value.
- Stack full with a higher priority pending: no take; the source stays pending until a pop.
- `i_rst` high mid-sequence: every register returns to its reset value at that edge, including an in-progress TAKE, which is aborted with `o_irq_take` low next cycle.

## Test plan
- Stray IRET: depth 0, pulse `i_iret` 3 times -> `o_depth` stays 0, `o_bad_iret` pulses 3 times, no take.
- Single: mask=FF, int_en=1, pulse req[3] -> one take with vector 16'h002C, depth 1; IRET -> depth 0, `o_in_service`=0.
- Nesting: req[5] taken (vector 0x0034), then req[2] -> second take with vector 0x0028, depth 2. Then req[6] -> pending only, no take. IRET, IRET -> depth 0, then req[6] is taken.
- Simultaneous req[1] and req[4] -> take of 1 first. After its IRET, 4 is taken. Mask bit 4 cleared -> 4 stays pending, no take.
- Full stack (depth 3) plus req[0] -> no take until an IRET. The take occurs 1 cycle after the pop, not during the IRET cycle.
- Reset asserted during TAKE -> next cycle all outputs at their reset values; a request re-asserted afterwards is taken normally.
